// File: rtl/mem_copy_engine.sv
// ============================================================================
// Module      : mem_copy_engine
// Description : Word-granular memory-to-memory copy with a bounded read FIFO.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_copy_engine #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  r_avalid,
    input  logic                  r_aready,
    input  logic                  r_dvalid,
    input  logic [DATA_WIDTH-1:0] r_data,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic                  w_valid,
    input  logic                  w_ready
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W:0] c_DEPTH = (c_CNT_W + 1)'(FIFO_DEPTH);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_COPY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [ADDR_WIDTH:0]   r_len;
    logic [ADDR_WIDTH:0]   r_reads_issued;
    logic [ADDR_WIDTH:0]   r_writes_done;
    logic [c_CNT_W-1:0]    r_outstanding;
    logic [c_CNT_W-1:0]    r_fifo_count;
    logic [c_PTR_W-1:0]    r_fifo_rd_ptr;
    logic [c_PTR_W-1:0]    r_fifo_wr_ptr;
    logic [DATA_WIDTH-1:0] r_fifo_mem [FIFO_DEPTH];

    logic [c_CNT_W:0]      w_inflight;
    logic                  w_rd_req;
    logic                  w_wr_req;
    logic                  w_rd_accept;
    logic                  w_rsp_push;
    logic                  w_wr_pop;

    // Reads in flight plus buffered words never exceed the FIFO, so a push
    // always has a free slot and never overwrites the head being written.
    assign w_inflight  = {1'b0, r_outstanding} + {1'b0, r_fifo_count};
    assign w_rd_req    = (r_state == c_COPY) && (r_reads_issued < r_len) &&
                         (w_inflight < c_DEPTH);
    assign w_wr_req    = (r_state == c_COPY) && (r_fifo_count != '0);
    assign w_rd_accept = w_rd_req && r_aready;
    assign w_rsp_push  = r_dvalid && (r_outstanding != '0);
    assign w_wr_pop    = w_wr_req && w_ready;

    assign busy     = (r_state != c_IDLE);
    assign done     = (r_state == c_DONE);
    assign r_avalid = w_rd_req;
    assign r_addr   = r_rd_addr;
    assign w_valid  = w_wr_req;
    assign w_addr   = r_wr_addr;
    assign w_data   = r_fifo_mem[r_fifo_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_IDLE;
            r_rd_addr      <= '0;
            r_wr_addr      <= '0;
            r_len          <= '0;
            r_reads_issued <= '0;
            r_writes_done  <= '0;
            r_outstanding  <= '0;
            r_fifo_count   <= '0;
            r_fifo_rd_ptr  <= '0;
            r_fifo_wr_ptr  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_mem[i] <= '0;
            end
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_rd_addr      <= src_addr;
                        r_wr_addr      <= dst_addr;
                        r_len          <= len;
                        r_reads_issued <= '0;
                        r_writes_done  <= '0;
                        r_state        <= (len == '0) ? c_DONE : c_COPY;
                    end
                end
                c_COPY: begin
                    if (w_rd_accept) begin
                        r_rd_addr      <= r_rd_addr + 1'b1;
                        r_reads_issued <= r_reads_issued + 1'b1;
                    end
                    if (w_wr_pop) begin
                        r_wr_addr     <= r_wr_addr + 1'b1;
                        r_writes_done <= r_writes_done + 1'b1;
                    end
                    if (r_writes_done == r_len) begin
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase

            // Acceptance and response in the same cycle cancel out.
            case ({w_rd_accept, w_rsp_push})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase

            case ({w_rsp_push, w_wr_pop})
                2'b10:   r_fifo_count <= r_fifo_count + 1'b1;
                2'b01:   r_fifo_count <= r_fifo_count - 1'b1;
                default: r_fifo_count <= r_fifo_count;
            endcase

            if (w_rsp_push) begin
                r_fifo_mem[r_fifo_wr_ptr] <= r_data;
                r_fifo_wr_ptr             <= r_fifo_wr_ptr + 1'b1;
            end
            if (w_wr_pop) begin
                r_fifo_rd_ptr <= r_fifo_rd_ptr + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_copy_engine.sv
// ============================================================================
// Module      : tb_mem_copy_engine
// Description : Scoreboard bench for mem_copy_engine with a latency memory model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_mem_copy_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  src_addr;
    logic [3:0]  dst_addr;
    logic [4:0]  len;
    logic        busy;
    logic        done;
    logic [3:0]  r_addr;
    logic        r_avalid;
    logic        r_aready;
    logic        r_dvalid;
    logic [31:0] r_data;
    logic [3:0]  w_addr;
    logic [31:0] w_data;
    logic        w_valid;
    logic        w_ready;

    mem_copy_engine #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(4),
        .FIFO_DEPTH(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .src_addr(src_addr),
        .dst_addr(dst_addr),
        .len     (len),
        .busy    (busy),
        .done    (done),
        .r_addr  (r_addr),
        .r_avalid(r_avalid),
        .r_aready(r_aready),
        .r_dvalid(r_dvalid),
        .r_data  (r_data),
        .w_addr  (w_addr),
        .w_data  (w_data),
        .w_valid (w_valid),
        .w_ready (w_ready)
    );

    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [31:0] mem [16];

    // Scoreboards: expected read addresses and expected writes, in order.
    logic [3:0]  exp_ra [$];
    logic [3:0]  exp_wa [$];
    logic [31:0] exp_wd [$];
    logic [31:0] rsp_d  [$];
    int          rsp_due[$];

    int cyc          = 0;
    int last_due     = 0;
    int lat_min      = 1;
    int lat_max      = 1;
    bit rand_ready   = 1'b0;
    bit hold_w       = 1'b0;
    int done_cnt     = 0;
    int av_cnt       = 0;
    int wv_cnt       = 0;
    int acc_cnt      = 0;
    int wr_cnt       = 0;
    int inflight     = 0;
    int max_inflight = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory model: random or fixed readiness, in-order read responses.
    initial begin
        r_aready = 1'b0;
        w_ready  = 1'b0;
        r_dvalid = 1'b0;
        r_data   = '0;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            r_dvalid = 1'b0;
            if (rsp_d.size() > 0 && rsp_due[0] <= cyc) begin
                r_dvalid = 1'b1;
                r_data   = rsp_d.pop_front();
                void'(rsp_due.pop_front());
            end
            r_aready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            w_ready  = hold_w ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
            if (!rst) begin
                if (r_avalid) av_cnt++;
                if (w_valid)  wv_cnt++;
                if (done)     done_cnt++;
                if (r_avalid && r_aready) begin
                    int due;
                    if (exp_ra.size() == 0) check("rd_unexpected", exp_ra.size(), 1);
                    else                    check("rd_addr", r_addr, exp_ra.pop_front());
                    due = cyc + int'($urandom_range(lat_min, lat_max));
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    rsp_d.push_back(mem[r_addr]);
                    rsp_due.push_back(due);
                    acc_cnt++;
                    inflight++;
                end
                if (w_valid && w_ready) begin
                    if (exp_wa.size() == 0) begin
                        check("wr_unexpected", exp_wa.size(), 1);
                    end else begin
                        check("wr_addr", w_addr, exp_wa.pop_front());
                        check("wr_data", w_data, exp_wd.pop_front());
                    end
                    wr_cnt++;
                    inflight--;
                end
                if (inflight > max_inflight) max_inflight = inflight;
            end
        end
    end

    task automatic start_copy(input logic [3:0] s, input logic [3:0] d, input logic [4:0] n);
        for (int i = 0; i < int'(n); i++) begin
            logic [3:0] sa;
            logic [3:0] da;
            sa = s + 4'(i);
            da = d + 4'(i);
            exp_ra.push_back(sa);
            exp_wa.push_back(da);
            exp_wd.push_back(mem[sa]);
        end
        done_cnt = 0;
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        len      = n;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (done_cnt == 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        check("done_pulses", done_cnt, 1);
        check("busy_after", busy, 0);
        check("wr_left", exp_wa.size(), 0);
        check("rd_left", exp_ra.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int k;
        int av0;
        int wv0;
        int w0;
        rst      = 1'b1;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len      = '0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        mem[2] = 32'hAAAA_0001;
        mem[3] = 32'hBBBB_0002;
        mem[4] = 32'hCCCC_0003;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_r_avalid", r_avalid, 0);
        check("rst_w_valid", w_valid, 0);
        check("rst_r_addr", r_addr, 0);
        check("rst_w_addr", w_addr, 0);
        check("rst_w_data", w_data, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic copy, latency 1, always ready
        start_copy(4'd2, 4'd9, 5'd3);
        wait_done(100);

        // Write backpressure holds the engine at FIFO_DEPTH reads
        hold_w  = 1'b1;
        acc_cnt = 0;
        start_copy(4'd0, 4'd8, 5'd8);
        repeat (20) @(negedge clk);
        check("bp_reads", acc_cnt, 4);
        check("bp_r_avalid", r_avalid, 0);
        check("bp_w_valid", w_valid, 1);
        check("bp_w_addr", w_addr, 4'd8);
        check("bp_w_data", w_data, mem[0]);
        hold_w = 1'b0;
        wait_done(200);

        // Address wrap on both ports
        start_copy(4'd14, 4'd15, 5'd4);
        wait_done(100);

        // Zero length
        done_cnt = 0;
        av0 = av_cnt;
        wv0 = wv_cnt;
        @(negedge clk);
        len   = 5'd0;
        start = 1'b1;
        k     = 0;
        while (k < 10) begin
            @(negedge clk);
            start = 1'b0;
            k++;
            if (done) break;
        end
        check("zero_done_latency_ok", (k >= 1 && k <= 2), 1);
        repeat (3) @(negedge clk);
        check("zero_done_pulses", done_cnt, 1);
        check("zero_r_avalid", av_cnt - av0, 0);
        check("zero_w_valid", wv_cnt - wv0, 0);
        check("zero_busy", busy, 0);

        // Start while busy is ignored
        lat_min = 2;
        lat_max = 2;
        start_copy(4'd1, 4'd6, 5'd6);
        repeat (2) @(negedge clk);
        src_addr = 4'd0;
        dst_addr = 4'd0;
        len      = 5'd2;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_done(200);

        // Reset mid-copy with reads outstanding
        lat_min = 4;
        lat_max = 4;
        w0 = wr_cnt;
        start_copy(4'd3, 4'd10, 5'd6);
        k = 0;
        while (wr_cnt - w0 < 2 && k < 200) begin
            @(negedge clk);
            k++;
        end
        rst = 1'b1;
        exp_ra.delete();
        exp_wa.delete();
        exp_wd.delete();
        inflight = 0;
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_r_avalid", r_avalid, 0);
        check("mid_rst_w_valid", w_valid, 0);
        check("mid_rst_r_addr", r_addr, 0);
        check("mid_rst_w_addr", w_addr, 0);
        check("mid_rst_w_data", w_data, 0);
        rst = 1'b0;
        wv0 = wv_cnt;
        repeat (12) @(negedge clk);
        check("late_rsp_w_valid", wv_cnt - wv0, 0);
        lat_min = 1;
        lat_max = 1;
        start_copy(4'd7, 4'd1, 5'd5);
        wait_done(200);

        // Random readiness and latency
        rand_ready   = 1'b1;
        lat_min      = 1;
        lat_max      = 5;
        inflight     = 0;
        max_inflight = 0;
        start_copy(4'd5, 4'd2, 5'd16);
        wait_done(2000);
        start_copy(4'd0, 4'd0, 5'd16);
        wait_done(2000);
        check("max_inflight_le_depth", (max_inflight <= 4), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

`default_nettype wire
